// File: rtl/sdram_address_unmapping.sv
// sdram_address_unmapping: turns a (bank, row, column) burst request back into
// a stream of linear byte addresses. It supports linear and wrapping bursts,
// and it mirrors the bank/row/column split done by the SDRAM address decoder.

package sdram_address_unmapping_pkg;

    // Geometry fields. The number of column bits is 8+cols, the number of
    // row bits is 11+rows, and the byte shift is dqsize.
    typedef struct packed {
        logic       iam;
        logic [1:0] rows;
        logic [1:0] cols;
        logic [1:0] dqsize;
    } ctrl_t;

    typedef struct packed {
        ctrl_t ctrl;
    } csr_t;

endpackage

module sdram_address_unmapping
    import sdram_address_unmapping_pkg::*;
#(
    parameter int ADDR_SIZE = 32,
    parameter int MAX_CSIZE = 11,
    parameter int MAX_RSIZE = 13,
    parameter int BA_SIZE   = 2,
    parameter int BLEN_SIZE = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  csr_t                 csr_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [BA_SIZE-1:0]   bank_i,
    input  logic [MAX_RSIZE-1:0] row_i,
    input  logic [MAX_CSIZE-1:0] column_i,
    input  logic [BLEN_SIZE-1:0] blen_i,
    input  logic                 wrap_i,
    output logic                 adr_valid_o,
    input  logic                 adr_ready_i,
    output logic [ADDR_SIZE-1:0] adr_o,
    output logic                 last_o
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t state, state_nxt;

    // The burst context is captured at the handshake. Later csr_i edits
    // therefore cannot disturb a burst that is already running.
    ctrl_t                ctl_q;
    logic [BA_SIZE-1:0]   bank_q;
    logic [MAX_RSIZE-1:0] row_q;
    logic [MAX_CSIZE-1:0] col_q;
    logic [BLEN_SIZE-1:0] blen_q;
    logic                 wrap_q;
    logic [BLEN_SIZE-1:0] cnt_q;

    logic                 handshake;
    logic                 beat_done;
    logic [MAX_CSIZE-1:0] col_nxt;
    logic [MAX_CSIZE-1:0] col_in;
    logic [MAX_RSIZE-1:0] row_in;

    // Column mask: the low 8+cols bits. A shift by the full width gives zero,
    // so the largest setting keeps every column bit.
    function automatic logic [MAX_CSIZE-1:0] col_mask(input ctrl_t c);
        int unsigned cw;
        cw = 32'd8 + 32'(c.cols);
        return ~({MAX_CSIZE{1'b1}} << cw);
    endfunction

    // Row mask: the low 11+rows bits. This is saturated by the row port width.
    function automatic logic [MAX_RSIZE-1:0] row_mask(input ctrl_t c);
        int unsigned rw;
        rw = 32'd11 + 32'(c.rows);
        return ~({MAX_RSIZE{1'b1}} << rw);
    endfunction

    // Build the word address from fields that are already masked, then scale
    // it to a byte address. With iam set, the bank sits between the column
    // and the row. Only bank[1:0] is used in that layout, so BA_SIZE >= 2.
    function automatic logic [ADDR_SIZE-1:0] compose(
        input logic [BA_SIZE-1:0]   b,
        input logic [MAX_RSIZE-1:0] r,
        input logic [MAX_CSIZE-1:0] c,
        input ctrl_t                ctl
    );
        int unsigned          cw;
        int unsigned          rw;
        logic [ADDR_SIZE-1:0] w;
        cw = 32'd8 + 32'(ctl.cols);
        rw = 32'd11 + 32'(ctl.rows);
        if (!ctl.iam)
            w = (ADDR_SIZE'(b) << (cw + rw)) | (ADDR_SIZE'(r) << cw) | ADDR_SIZE'(c);
        else
            w = (ADDR_SIZE'(r) << (cw + 32'd2)) | (ADDR_SIZE'(b[1:0]) << cw) | ADDR_SIZE'(c);
        return w << ctl.dqsize;
    endfunction

    assign handshake   = req_valid_i && req_ready_o;
    assign beat_done   = adr_valid_o && adr_ready_i;
    assign req_ready_o = (state == IDLE);
    assign adr_valid_o = (state == BURST);

    assign col_in = column_i & col_mask(csr_i.ctrl);
    assign row_in = row_i & row_mask(csr_i.ctrl);

    // Next column for each burst type.
    // A wrapping burst only moves inside the aligned group of size blen+1,
    // which must be a power of two, so blen is itself the in-group mask.
    // A linear burst rolls over at the end of the row and stays in that row.
    always_comb begin
        col_nxt = col_q + MAX_CSIZE'(1);
        if (wrap_q)
            col_nxt = (col_q & ~MAX_CSIZE'(blen_q)) | (col_nxt & MAX_CSIZE'(blen_q));
        col_nxt = col_nxt & col_mask(ctl_q);
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic: accept a request while idle, and leave BURST when
    // the final beat has been taken.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid_i)          state_nxt = BURST;
            BURST:   if (beat_done && last_o)  state_nxt = IDLE;
            default:                           state_nxt = IDLE;
        endcase
    end

    // Burst context and registered beat outputs. The outputs only advance
    // when a beat completes, so they hold steady while the consumer stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctl_q  <= '0;
            bank_q <= '0;
            row_q  <= '0;
            col_q  <= '0;
            blen_q <= '0;
            wrap_q <= 1'b0;
            cnt_q  <= '0;
            adr_o  <= '0;
            last_o <= 1'b0;
        end else if (handshake) begin
            ctl_q  <= csr_i.ctrl;
            bank_q <= bank_i;
            row_q  <= row_in;
            col_q  <= col_in;
            blen_q <= blen_i;
            wrap_q <= wrap_i;
            cnt_q  <= '0;
            adr_o  <= compose(bank_i, row_in, col_in, csr_i.ctrl);
            last_o <= (blen_i == '0);
        end else if (beat_done) begin
            if (last_o) begin
                last_o <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q  <= cnt_q + BLEN_SIZE'(1);
                col_q  <= col_nxt;
                adr_o  <= compose(bank_q, row_q, col_nxt, ctl_q);
                last_o <= ((cnt_q + BLEN_SIZE'(1)) == blen_q);
            end
        end
    end

endmodule

// File: tb/tb_sdram_address_unmapping.sv
// Scoreboard bench for sdram_address_unmapping. Directed steps push the
// expected beats, and a negedge monitor pops and checks each beat the
// consumer accepts.
module tb_sdram_address_unmapping;
    import sdram_address_unmapping_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    csr_t        csr_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  bank_i;
    logic [12:0] row_i;
    logic [10:0] column_i;
    logic [3:0]  blen_i;
    logic        wrap_i;
    logic        adr_valid_o;
    logic        adr_ready_i;
    logic [31:0] adr_o;
    logic        last_o;

    typedef struct {
        logic [31:0] adr;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_seen = '0;

    sdram_address_unmapping dut (
        .clk_i(clk_i), .rst_i(rst_i), .csr_i(csr_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .bank_i(bank_i), .row_i(row_i), .column_i(column_i),
        .blen_i(blen_i), .wrap_i(wrap_i),
        .adr_valid_o(adr_valid_o), .adr_ready_i(adr_ready_i),
        .adr_o(adr_o), .last_o(last_o)
    );

    always #5 clk_i = ~clk_i;

    // Check every accepted beat against the head of the scoreboard.
    always @(negedge clk_i) begin
        if (!rst_i && adr_valid_o && adr_ready_i) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_beat adr=%h last=%b", adr_o, last_o);
            end
            if (exp_q.size() != 0) begin
                beat_t e;
                e = exp_q.pop_front();
                checks++;
                assert (adr_o === e.adr) else begin
                    errors++;
                    $error("FAIL beat_adr obs=%h exp=%h", adr_o, e.adr);
                end
                checks++;
                assert (last_o === e.last) else begin
                    errors++;
                    $error("FAIL beat_last adr=%h obs=%b exp=%b", adr_o, last_o, e.last);
                end
            end
            last_seen = adr_o;
        end
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
        end
    endtask

    task automatic set_csr(input logic iam, input logic [1:0] rows, input logic [1:0] cols,
                           input logic [1:0] dq);
        csr_i.ctrl.iam    = iam;
        csr_i.ctrl.rows   = rows;
        csr_i.ctrl.cols   = cols;
        csr_i.ctrl.dqsize = dq;
    endtask

    task automatic push(input logic [31:0] a, input logic l);
        beat_t e;
        e.adr  = a;
        e.last = l;
        exp_q.push_back(e);
    endtask

    // Reference address computed directly from the bit layout of the two
    // address maps.
    function automatic logic [31:0] model(input logic [1:0] b, input logic [12:0] r,
                                          input logic [10:0] c);
        int          cw;
        int          rw;
        logic [63:0] cm;
        logic [63:0] rm;
        logic [63:0] w;
        cw = 8 + int'(csr_i.ctrl.cols);
        rw = 11 + int'(csr_i.ctrl.rows);
        cm = (64'd1 << cw) - 1;
        rm = ((64'd1 << rw) - 1) & 64'h1FFF;
        if (!csr_i.ctrl.iam)
            w = (64'(b) << (cw + rw)) | ((64'(r) & rm) << cw) | (64'(c) & cm);
        else
            w = ((64'(r) & rm) << (cw + 2)) | (64'(b) << cw) | (64'(c) & cm);
        return 32'(w << csr_i.ctrl.dqsize);
    endfunction

    // Push the first n beats of a burst, using the current csr.
    task automatic push_model(input logic [1:0] b, input logic [12:0] r, input logic [10:0] c,
                              input logic [3:0] bl, input logic w, input int n);
        int         cw;
        logic [10:0] cm;
        logic [10:0] c0;
        logic [10:0] col;
        cw = 8 + int'(csr_i.ctrl.cols);
        cm = 11'((32'd1 << cw) - 1);
        c0 = c & cm;
        for (int i = 0; i < n; i++) begin
            if (w) col = (c0 & ~11'(bl)) | ((c0 + 11'(i)) & 11'(bl));
            else   col = (c0 + 11'(i)) & cm;
            push(model(b, r, col), i == int'(bl));
        end
    endtask

    task automatic send(input logic [1:0] b, input logic [12:0] r, input logic [10:0] c,
                        input logic [3:0] bl, input logic w);
        int n = 0;
        while (!req_ready_o && n < 50) begin tick(); n++; end
        chk("req_ready_wait", 32'(req_ready_o), 32'd1);
        bank_i = b; row_i = r; column_i = c; blen_i = bl; wrap_i = w;
        req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic drain;
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin tick(); n++; end
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        n = 0;
        while (adr_valid_o && n < 10) begin tick(); n++; end
        chk("drain_idle_valid", 32'(adr_valid_o), 32'd0);
    endtask

    initial begin
        logic [31:0] rec_adr;
        logic        rec_last;
        rst_i = 1'b1; req_valid_i = 1'b0; adr_ready_i = 1'b1;
        bank_i = '0; row_i = '0; column_i = '0; blen_i = '0; wrap_i = 1'b0;
        set_csr(1'b0, 2'd2, 2'd1, 2'd1);
        tick(); tick();
        chk("rst_valid", 32'(adr_valid_o), 32'd0);
        chk("rst_last", 32'(last_o), 32'd0);
        chk("rst_adr", adr_o, 32'd0);
        chk("rst_ready", 32'(req_ready_o), 32'd1);
        rst_i = 1'b0;
        tick();

        // Linear burst of four beats, with the request channel busy meanwhile.
        push(32'h1001420, 1'b0); push(32'h1001422, 1'b0);
        push(32'h1001424, 1'b0); push(32'h1001426, 1'b1);
        send(2'd2, 13'h005, 11'h010, 4'd3, 1'b0);
        chk("busy_ready", 32'(req_ready_o), 32'd0);
        chk("first_beat_valid", 32'(adr_valid_o), 32'd1);
        drain();

        // Wrapping burst of eight beats, starting mid-group.
        push(32'h100142C, 1'b0); push(32'h100142E, 1'b0);
        push(32'h1001420, 1'b0); push(32'h1001422, 1'b0);
        push(32'h1001424, 1'b0); push(32'h1001426, 1'b0);
        push(32'h1001428, 1'b0); push(32'h100142A, 1'b1);
        send(2'd2, 13'h005, 11'h016, 4'd7, 1'b1);
        drain();

        // iam layout, where the column rolls over to 0 inside the row.
        set_csr(1'b1, 2'd0, 2'd0, 2'd2);
        push(32'h37FC, 1'b0); push(32'h3400, 1'b1);
        send(2'd1, 13'h003, 11'h0FF, 4'd1, 1'b0);
        drain();

        // A single-beat burst, with high row/column bits to be ignored.
        set_csr(1'b0, 2'd0, 2'd0, 2'd0);
        push_model(2'd3, 13'h1FFF, 11'h7AB, 4'd0, 1'b0, 1);
        send(2'd3, 13'h1FFF, 11'h7AB, 4'd0, 1'b0);
        drain();

        // Stall for five cycles while csr toggles.
        set_csr(1'b0, 2'd2, 2'd1, 2'd1);
        adr_ready_i = 1'b0;
        push_model(2'd1, 13'h123, 11'h1FE, 4'd3, 1'b0, 4);
        send(2'd1, 13'h123, 11'h1FE, 4'd3, 1'b0);
        adr_ready_i = 1'b1;
        tick();
        adr_ready_i = 1'b0;
        rec_adr = adr_o; rec_last = last_o;
        for (int i = 0; i < 5; i++) begin
            csr_i = csr_t'(7'($urandom));
            tick();
            chk("stall_adr", adr_o, rec_adr);
            chk("stall_last", 32'(last_o), 32'(rec_last));
            chk("stall_valid", 32'(adr_valid_o), 32'd1);
        end
        set_csr(1'b0, 2'd2, 2'd1, 2'd1);
        adr_ready_i = 1'b1;
        drain();

        // Reset while beat 2 of an eight-beat burst is on the outputs.
        adr_ready_i = 1'b0;
        push_model(2'd0, 13'h0AA, 11'h040, 4'd7, 1'b0, 2);
        send(2'd0, 13'h0AA, 11'h040, 4'd7, 1'b0);
        adr_ready_i = 1'b1;
        tick(); tick();
        adr_ready_i = 1'b0;
        chk("pre_reset_popped", 32'(exp_q.size()), 32'd0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("midrst_valid", 32'(adr_valid_o), 32'd0);
        chk("midrst_ready", 32'(req_ready_o), 32'd1);
        chk("midrst_last", 32'(last_o), 32'd0);
        adr_ready_i = 1'b1;
        push_model(2'd3, 13'h0BB, 11'h0F1, 4'd1, 1'b0, 2);
        send(2'd3, 13'h0BB, 11'h0F1, 4'd1, 1'b0);
        drain();

        // Back-to-back requests.
        push_model(2'd1, 13'h011, 11'h003, 4'd3, 1'b1, 4);
        push_model(2'd2, 13'h022, 11'h005, 4'd1, 1'b0, 2);
        send(2'd1, 13'h011, 11'h003, 4'd3, 1'b1);
        send(2'd2, 13'h022, 11'h005, 4'd1, 1'b0);
        drain();

        // Random round trip through the decoder, plus random multi-beat bursts.
        for (int k = 0; k < 20; k++) begin
            logic [1:0]  b;
            logic [12:0] r;
            logic [10:0] c;
            logic [3:0]  bl;
            logic        w;
            int          cw;
            int          rw;
            logic [31:0] word;
            logic [31:0] cm;
            logic [31:0] rm;
            csr_i = csr_t'(7'($urandom));
            b = 2'($urandom); r = 13'($urandom); c = 11'($urandom);
            if (k < 16) begin
                push_model(b, r, c, 4'd0, 1'b0, 1);
                send(b, r, c, 4'd0, 1'b0);
                drain();
                cw = 8 + int'(csr_i.ctrl.cols);
                rw = 11 + int'(csr_i.ctrl.rows);
                cm = (32'd1 << cw) - 1;
                rm = ((32'd1 << rw) - 1) & 32'h1FFF;
                word = last_seen >> csr_i.ctrl.dqsize;
                if (!csr_i.ctrl.iam) begin
                    chk("dec_bank", (word >> (cw + rw)) & 32'd3, 32'(b));
                    chk("dec_row", (word >> cw) & rm, 32'(r) & rm);
                end else begin
                    chk("dec_bank", (word >> cw) & 32'd3, 32'(b));
                    chk("dec_row", (word >> (cw + 2)) & rm, 32'(r) & rm);
                end
                chk("dec_col", word & cm, 32'(c) & cm);
            end else begin
                bl = 4'((32'd1 << $urandom_range(0, 4)) - 1);
                w  = 1'($urandom);
                push_model(b, r, c, bl, w, int'(bl) + 1);
                send(b, r, c, bl, w);
                drain();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_address_unmapping.md
SDRAM_ADDRESS_UNMAPPING -- requirements
Module: sdram_address_unmapping

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 32, width of reconstructed linear byte address.
REQ-002 SHALL have parameter MAX_CSIZE, default 11, max column address bits.
REQ-003 SHALL have parameter MAX_RSIZE, default 13, max row address bits.
REQ-004 SHALL have parameter BA_SIZE, default 2, bank address bits.
REQ-005 SHALL have parameter BLEN_SIZE, default 4, width of burst-length field.
REQ-006 clk_i  input  1  single clock; all state updates on rising edge.
REQ-007 rst_i  input  1  reset, synchronous, active-high.
REQ-008 csr_i  input  csr_t  control/status; uses ctrl.dqsize, ctrl.cols, ctrl.rows, ctrl.iam.
REQ-009 req_valid_i  input  1  burst request valid.
REQ-010 req_ready_o  output  1  block can accept a request.
REQ-011 bank_i / row_i / column_i  input  BA_SIZE / MAX_RSIZE / MAX_CSIZE  start location.
REQ-012 blen_i  input  BLEN_SIZE  beats minus one.
REQ-013 wrap_i  input  1  1 = wrapping burst, 0 = linear burst.
REQ-014 adr_valid_o  output  1  adr_o/last_o valid.
REQ-015 adr_ready_i  input  1  consumer accepts current beat.
REQ-016 adr_o  output  ADDR_SIZE  reconstructed linear byte address.
REQ-017 last_o  output  1  current beat is the final beat of the burst.

Function
REQ-018 SHALL derive C = 8 + ctrl.cols, R = 11 + ctrl.rows, D = ctrl.dqsize (shift amount).
REQ-019 SHALL mask column to C LSBs and row to R LSBs before composing.
REQ-020 With iam=0, SHALL compose word = (bank << (C+R)) | (row << C) | col.
REQ-021 With iam=1, SHALL compose word = (row << (C+2)) | (bank[1:0] << C) | col.
REQ-022 SHALL output adr_o = (word << D), truncated to ADDR_SIZE bits; exact inverse of the team's bank/row/column decoder for in-range addresses.
REQ-023 FSM states IDLE and BURST; reset state IDLE.
REQ-024 req_ready_o SHALL be 1 in IDLE and 0 in BURST; handshake occurs when req_valid_i & req_ready_o.
REQ-025 On handshake, SHALL register bank, row, column, blen, wrap and the csr_i fields used; transition to BURST; csr_i changes during BURST SHALL NOT affect the burst.
REQ-026 First beat SHALL appear with adr_valid_o=1 in the cycle after the handshake (1-cycle latency); adr_o SHALL be registered.
REQ-027 A beat completes when adr_valid_o & adr_ready_i; while adr_ready_i=0, adr_o, last_o and adr_valid_o SHALL hold stable.
REQ-028 Beat counter SHALL count 0..blen; last_o = 1 exactly when counter == blen.
REQ-029 Linear burst: column SHALL increment by 1 per beat, modulo 2^C (wraps to 0 inside the same row and bank; row and bank never change).
REQ-030 Wrapping burst: column SHALL increment modulo (blen+1) inside the (blen+1)-aligned group; upper column bits held. blen+1 SHALL be a power of two; other values are unsupported.
REQ-031 blen=0 SHALL produce exactly one beat with last_o=1.
REQ-032 On completion of the last beat, SHALL return to IDLE; adr_valid_o=0 in the following cycle, and back-to-back requests incur one idle cycle.
REQ-033 row_i bits above R and column_i bits above C SHALL be ignored.

Reset
REQ-034 With rst_i=1 at a clock edge: state IDLE, adr_valid_o=0, last_o=0, adr_o=0, beat counter=0; req_ready_o=1 the cycle after.
REQ-035 Reset mid-burst SHALL abandon the burst with no further beats; no residual state.

Verification
REQ-036 iam=0, cols=01, rows=10, dqsize=1, bank=2, row=0x005, col=0x010, blen=3, linear -> adr_o 0x1001420, 0x1001422, 0x1001424, 0x1001426; last_o on 4th beat only.
REQ-037 Same csr, col=0x016, blen=7, wrap=1 -> column sequence 0x16, 0x17, 0x10 ... 0x15; first adr_o 0x100142C, third 0x1001420.
REQ-038 iam=1, cols=00, dqsize=2, bank=1, row=3, col=0xFF, blen=1, linear -> adr_o 0x37FC then 0x3400 (column wraps to 0).
REQ-039 Hold adr_ready_i=0 for 5 cycles mid-burst -> outputs stable, no beat skipped or duplicated; toggle csr_i meanwhile -> addresses unchanged.
REQ-040 Assert rst_i during beat 2 of a blen=7 burst -> adr_valid_o=0 the next cycle, req_ready_o=1; a new request then runs from beat 0.
REQ-041 Random bank/row/column/csr: feed adr_o through the team's address decoder -> recovered bank/row/column equal the first-beat inputs.
